// File: rtl/chargen_src.sv
// RFC 864-style character generator: rotating printable-ASCII lines ended by CR LF,
// offered downstream through an active-low valid/ready handshake.
module chargen_src #(
  parameter int unsigned LINE_LEN = 72,
  parameter logic [7:0]  FIRST    = 8'h20,
  parameter logic [7:0]  LAST     = 8'h7E
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       n_en,
  input  logic       n_ready,
  output logic       n_valid,
  output logic [7:0] data
);

  localparam int unsigned COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_CHAR = 2'd0,
    ST_CR   = 2'd1,
    ST_LF   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       cur_q, cur_d;
  logic [7:0]       line_start_q, line_start_d;
  logic             n_valid_q, n_valid_d;
  logic [7:0]       data_q, data_d;
  logic             xfer;

  // Next character in the rotation, wrapping LAST back to FIRST.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v);
    return (v == LAST) ? FIRST : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_CHAR;
      col_q        <= '0;
      cur_q        <= FIRST;
      line_start_q <= FIRST;
      n_valid_q    <= 1'b1;
      data_q       <= FIRST;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      cur_q        <= cur_d;
      line_start_q <= line_start_d;
      n_valid_q    <= n_valid_d;
      data_q       <= data_d;
    end
  end

  // Sequence advance on transfer; data register is preloaded with the byte of the next state.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    cur_d        = cur_q;
    line_start_d = line_start_q;
    n_valid_d    = n_en;
    data_d       = data_q;
    xfer         = !n_valid_q && !n_ready;

    if (xfer) begin
      case (state_q)
        ST_CHAR: begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_CR;
          end else begin
            col_d = col_q + COL_W'(1);
            cur_d = wrap_inc(cur_q);
          end
        end
        ST_CR: state_d = ST_LF;
        ST_LF: begin
          line_start_d = wrap_inc(line_start_q);
          cur_d        = wrap_inc(line_start_q);
          state_d      = ST_CHAR;
        end
        default: state_d = ST_CHAR;
      endcase
    end

    case (state_d)
      ST_CR:   data_d = CHAR_CR;
      ST_LF:   data_d = CHAR_LF;
      default: data_d = cur_d;
    endcase
  end

  assign n_valid = n_valid_q;
  assign data    = data_q;

endmodule

// File: tb/tb_chargen_src.sv
// Self-checking bench for chargen_src: two configurations share stimulus and are
// compared against an arithmetic model of the byte stream.
module tb_chargen_src;

  logic       clk;
  logic       n_rst;
  logic       n_en;
  logic       n_ready;
  logic       n_valid_a, n_valid_b;
  logic [7:0] data_a, data_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: expected n_valid and number of bytes transferred so far.
  logic ev;
  int   cnt_a, cnt_b;

  chargen_src #(.LINE_LEN(4)) dut_a (
    .clk(clk), .n_rst(n_rst), .n_en(n_en), .n_ready(n_ready),
    .n_valid(n_valid_a), .data(data_a)
  );

  chargen_src #(.LINE_LEN(2), .FIRST(8'h41), .LAST(8'h43)) dut_b (
    .clk(clk), .n_rst(n_rst), .n_en(n_en), .n_ready(n_ready),
    .n_valid(n_valid_b), .data(data_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // k-th byte of the infinite stream, derived from line/column arithmetic.
  function automatic logic [7:0] ref_byte(input int k, input int ll, input int first, input int last);
    int n, line, pos;
    n    = last - first + 1;
    line = k / (ll + 2);
    pos  = k % (ll + 2);
    if (pos < ll) return 8'(first + (line + pos) % n);
    else if (pos == ll) return 8'h0D;
    else return 8'h0A;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("a_valid", {7'b0, n_valid_a}, {7'b0, ev});
    chk("a_data", data_a, ref_byte(cnt_a, 4, 32'h20, 32'h7E));
    chk("b_valid", {7'b0, n_valid_b}, {7'b0, ev});
    chk("b_data", data_b, ref_byte(cnt_b, 2, 32'h41, 32'h43));
  endtask

  // One clock: predict from the inputs seen at the edge, then compare after it.
  task automatic step();
    bit xf, nev;
    xf  = n_rst && !ev && !n_ready;
    nev = n_rst ? n_en : 1'b1;
    @(posedge clk);
    #1;
    if (!n_rst) begin
      cnt_a = 0; cnt_b = 0; ev = 1'b1;
    end else begin
      if (xf) begin cnt_a++; cnt_b++; end
      ev = nev;
    end
    check_models();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    cnt_a = 0; cnt_b = 0; ev = 1'b1;
    chk("rst_valid", {7'b0, n_valid_a}, 8'h01);
    chk("rst_data_a", data_a, 8'h20);
    chk("rst_data_b", data_b, 8'h41);
    step();
    n_rst = 1'b1;
  endtask

  typedef struct {
    logic       n_en;
    logic       n_ready;
    logic       n_valid;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [7:0] seq_a [16];
    logic [7:0] seq_b [16];
    bit found;

    seq_a = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h0D, 8'h0A, 8'h21, 8'h22,
              8'h23, 8'h24, 8'h0D, 8'h0A, 8'h22, 8'h23, 8'h24, 8'h25};
    seq_b = '{8'h41, 8'h42, 8'h0D, 8'h0A, 8'h42, 8'h43, 8'h0D, 8'h0A,
              8'h43, 8'h41, 8'h0D, 8'h0A, 8'h41, 8'h42, 8'h0D, 8'h0A};
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, seq_a[i], seq_b[i]};

    n_rst = 1'b1; n_en = 1'b0; n_ready = 1'b0;
    ev = 1'b1; cnt_a = 0; cnt_b = 0;
    #1;

    // Reset, first line, and wrap in the small alphabet: one byte per clock.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      n_en = tbl[i].n_en; n_ready = tbl[i].n_ready;
      step();
      chk("tbl_valid", {7'b0, n_valid_a}, {7'b0, tbl[i].n_valid});
      chk("tbl_a", data_a, tbl[i].exp_a);
      chk("tbl_b", data_b, tbl[i].exp_b);
    end

    // Backpressure while 0x22 is on offer.
    n_en = 1'b0; n_ready = 1'b0;
    do_reset();
    repeat (3) step();
    chk("bp_offer", data_a, 8'h22);
    n_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", data_a, 8'h22);
      chk("bp_valid", {7'b0, n_valid_a}, 8'h00);
    end
    n_ready = 1'b0;
    step();
    chk("bp_next", data_a, 8'h23);

    // Run to 0x25, pause, re-enable, then drop enable on a transfer edge.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (data_a == 8'h25) found = 1'b1;
    end
    chk("reach_25", {7'b0, found}, 8'h01);
    n_en = 1'b1; n_ready = 1'b1;
    step();
    chk("pause_valid", {7'b0, n_valid_a}, 8'h01);
    chk("pause_data", data_a, 8'h25);
    n_en = 1'b0;
    step();
    chk("resume_valid", {7'b0, n_valid_a}, 8'h00);
    chk("resume_data", data_a, 8'h25);
    n_en = 1'b1; n_ready = 1'b0;
    step();
    chk("sim_valid", {7'b0, n_valid_a}, 8'h01);
    chk("sim_next", data_a, 8'h0D);

    // Reset in the middle of a line.
    n_en = 1'b0; n_ready = 1'b0;
    do_reset();
    repeat (9) step();
    do_reset();
    step();
    chk("mid_first", data_a, 8'h20);
    repeat (4) step();
    chk("mid_cr", data_a, 8'h0D);

    // Random enable/backpressure with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      n_en    = ($urandom_range(0, 3) == 0);
      n_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
